// File: rtl/hangman_guess_engine.sv
// Hangman guess engine: latches a word, evaluates one committed guess per go pulse,
// tracks revealed letters and wrong guesses. Optional HANGMAN_GUESS_HISTORY_EN rejects repeated guesses.
module hangman_guess_engine #(
  parameter  int MAX_LEN   = 8,
  parameter  int MAX_WRONG = 6,
  localparam int LW        = $clog2(MAX_LEN + 1),
  localparam int WW        = $clog2(MAX_WRONG + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 new_game,
  input  logic [5*MAX_LEN-1:0] word,
  input  logic [LW-1:0]        word_len,
  input  logic [4:0]           guess,
  input  logic                 go,
  output logic [MAX_LEN-1:0]   revealed,
  output logic [WW-1:0]        wrong_count,
  output logic                 hit,
  output logic                 miss,
  output logic                 invalid,
  output logic                 game_won,
  output logic                 game_lost
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_ARMED = 3'd2,
    S_EVAL  = 3'd3,
    S_WON   = 3'd4,
    S_LOST  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [5*MAX_LEN-1:0] word_q, word_d;
  logic [LW-1:0]        len_q, len_d;
  logic [4:0]           guess_q, guess_d;
  logic [MAX_LEN-1:0]   revealed_q, revealed_d;
  logic [WW-1:0]        wrong_q, wrong_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 invalid_q, invalid_d;
  logic                 won_q, won_d;
  logic                 lost_q, lost_d;

  logic [LW-1:0]        len_clamp_s;
  logic [MAX_LEN-1:0]   len_mask_s;
  logic [MAX_LEN-1:0]   match_s;
  logic                 all_rev_s;
  logic                 dup_s;
  logic                 valid_s;

  // Clamp the requested length to the word capacity.
  always_comb begin
    if (int'(word_len) > MAX_LEN) begin
      len_clamp_s = LW'(MAX_LEN);
    end else begin
      len_clamp_s = word_len;
    end
  end

  // Parallel compare of the held guess against every active letter position.
  always_comb begin
    len_mask_s = '0;
    match_s    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (int'(len_q) > i) begin
        len_mask_s[i] = 1'b1;
        match_s[i]    = (word_q[5*i +: 5] == guess_q);
      end else begin
        len_mask_s[i] = 1'b0;
        match_s[i]    = 1'b0;
      end
    end
  end

  assign all_rev_s = (((revealed_q | match_s) & len_mask_s) == len_mask_s);
  assign valid_s   = (guess_q <= 5'd25) && !dup_s;

`ifdef HANGMAN_GUESS_HISTORY_EN
  logic [25:0] hist_q;
  logic [31:0] hist_ext_s;

  assign hist_ext_s = {6'd0, hist_q};
  assign dup_s      = hist_ext_s[guess_q];

  // Record each valid evaluated letter so a repeat is rejected as invalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= 26'd0;
    end else if (new_game) begin
      hist_q <= 26'd0;
    end else if ((state_q == S_EVAL) && valid_s) begin
      hist_q <= hist_q | (26'd1 << guess_q);
    end else begin
      hist_q <= hist_q;
    end
  end
`else
  assign dup_s = 1'b0;
`endif

  // Next-state and registered-output logic; new_game overrides everything.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    len_d      = len_q;
    guess_d    = guess_q;
    revealed_d = revealed_q;
    wrong_d    = wrong_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    invalid_d  = 1'b0;
    if (new_game) begin
      word_d     = word;
      len_d      = len_clamp_s;
      revealed_d = '0;
      wrong_d    = '0;
      if (len_clamp_s == '0) begin
        state_d = S_WON;
      end else begin
        state_d = S_PLAY;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_PLAY: begin
          if (go) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_ARMED: begin
          if (go) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_EVAL;
            guess_d = guess;
          end
        end
        S_EVAL: begin
          if (!valid_s) begin
            invalid_d = 1'b1;
            state_d   = S_PLAY;
          end else if (|match_s) begin
            hit_d      = 1'b1;
            revealed_d = revealed_q | match_s;
            if (all_rev_s) begin
              state_d = S_WON;
            end else begin
              state_d = S_PLAY;
            end
          end else begin
            miss_d = 1'b1;
            if (wrong_q < WW'(MAX_WRONG)) begin
              wrong_d = wrong_q + WW'(1);
            end else begin
              wrong_d = wrong_q;
            end
            if (wrong_d >= WW'(MAX_WRONG)) begin
              state_d = S_LOST;
            end else begin
              state_d = S_PLAY;
            end
          end
        end
        S_WON: begin
          state_d = S_WON;
        end
        S_LOST: begin
          state_d = S_LOST;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    won_d  = (state_d == S_WON);
    lost_d = (state_d == S_LOST);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      len_q      <= '0;
      guess_q    <= 5'd0;
      revealed_q <= '0;
      wrong_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      invalid_q  <= 1'b0;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      len_q      <= len_d;
      guess_q    <= guess_d;
      revealed_q <= revealed_d;
      wrong_q    <= wrong_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      invalid_q  <= invalid_d;
      won_q      <= won_d;
      lost_q     <= lost_d;
    end
  end

  assign revealed    = revealed_q;
  assign wrong_count = wrong_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign invalid     = invalid_q;
  assign game_won    = won_q;
  assign game_lost   = lost_q;

endmodule

// File: tb/tb_hangman_guess_engine.sv
// Directed testbench for hangman_guess_engine (default MAX_LEN=8, MAX_WRONG=6).
module tb_hangman_guess_engine;

  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        new_game = 1'b0;
  logic [39:0] word = 40'd0;
  logic [3:0]  word_len = 4'd0;
  logic [4:0]  guess = 5'd0;
  logic        go = 1'b0;
  logic [7:0]  revealed;
  logic [2:0]  wrong_count;
  logic        hit, miss, invalid, game_won, game_lost;

  int vectors = 0;
  int miscompares = 0;

  logic p_hit, p_miss, p_inv, p_after;

  localparam logic [39:0] BOOK = {20'd0, 5'd10, 5'd14, 5'd14, 5'd1};
  localparam logic [39:0] STAY = {20'd0, 5'd24, 5'd0, 5'd19, 5'd18};

  hangman_guess_engine #(.MAX_LEN(8), .MAX_WRONG(6)) dut (
    .clk(clk), .resetn(resetn), .new_game(new_game), .word(word), .word_len(word_len),
    .guess(guess), .go(go), .revealed(revealed), .wrong_count(wrong_count),
    .hit(hit), .miss(miss), .invalid(invalid), .game_won(game_won), .game_lost(game_lost)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [39:0] w, input logic [3:0] len);
    word = w; word_len = len; new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  // go pulse, then disturb guess during EVAL; capture pulse and the cycle after
  task automatic do_guess(input logic [4:0] g);
    guess = g; go = 1'b1;
    step();
    go = 1'b0;
    step();
    guess = 5'd31;
    step();
    p_hit = hit; p_miss = miss; p_inv = invalid;
    step();
    p_after = hit | miss | invalid;
    guess = 5'd0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(); step();
    vectors++;
    if ({revealed, wrong_count, hit, miss, invalid, game_won, game_lost} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h exp 0000", {revealed, wrong_count, hit, miss, invalid, game_won, game_lost});
    end
    resetn = 1'b1;
    step();
    do_guess(5'd14);
    vectors++;
    if ({p_hit, p_miss, p_inv, p_after, revealed, wrong_count} !== 15'd0) begin
      miscompares++;
      $display("FAIL idle_ignores_guess got %h exp 0000", {p_hit, p_miss, p_inv, p_after, revealed, wrong_count});
    end
  endtask

  task automatic test_reveal();
    start_game(BOOK, 4'd4);
    do_guess(5'd14);
    vectors++;
    if ({p_hit, p_miss, p_inv, p_after} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reveal_pulse got %b exp 1000", {p_hit, p_miss, p_inv, p_after});
    end
    vectors++;
    if ({revealed, wrong_count} !== {8'b0000_0110, 3'd0}) begin
      miscompares++;
      $display("FAIL reveal_state got %b/%0d exp 00000110/0", revealed, wrong_count);
    end
    do_guess(5'd0);
    vectors++;
    if ({p_hit, p_miss, revealed, wrong_count} !== {1'b0, 1'b1, 8'b0000_0110, 3'd1}) begin
      miscompares++;
      $display("FAIL beyond_len_ignored got %b%b %b/%0d exp 01 00000110/1", p_hit, p_miss, revealed, wrong_count);
    end
  endtask

  task automatic test_win();
    logic [4:0] gs [4];
    gs = '{5'd18, 5'd19, 5'd0, 5'd24};
    start_game(STAY, 4'd4);
    for (int i = 0; i < 4; i++) begin
      do_guess(gs[i]);
      vectors++;
      if ({p_hit, game_won, revealed} !== {1'b1, (i == 3), 8'((1 << (i + 1)) - 1)}) begin
        miscompares++;
        $display("FAIL win_step%0d got hit=%b won=%b rev=%b", i, p_hit, game_won, revealed);
      end
    end
    do_guess(5'd3);
    vectors++;
    if ({p_hit, p_miss, p_inv, p_after, game_won, revealed, wrong_count} !== {4'b0000, 1'b1, 8'h0F, 3'd0}) begin
      miscompares++;
      $display("FAIL won_ignores_guess got %b%b%b%b won=%b rev=%b wc=%0d", p_hit, p_miss, p_inv, p_after, game_won, revealed, wrong_count);
    end
  endtask

  task automatic test_loss();
    start_game(STAY, 4'd4);
    for (int i = 1; i <= 6; i++) begin
      do_guess(5'(i));
      vectors++;
      if ({p_miss, p_hit, wrong_count, game_lost} !== {1'b1, 1'b0, 3'(i), (i == 6)}) begin
        miscompares++;
        $display("FAIL loss_step%0d got miss=%b hit=%b wc=%0d lost=%b exp wc=%0d", i, p_miss, p_hit, wrong_count, game_lost, i);
      end
    end
    do_guess(5'd7);
    vectors++;
    if ({p_miss, p_hit, p_inv, wrong_count, game_lost} !== {3'b000, 3'd6, 1'b1}) begin
      miscompares++;
      $display("FAIL loss_saturate got %b%b%b wc=%0d lost=%b exp 000 wc=6 lost=1", p_miss, p_hit, p_inv, wrong_count, game_lost);
    end
  endtask

  task automatic test_invalid();
    start_game(STAY, 4'd4);
    do_guess(5'd18);
    do_guess(5'd30);
    vectors++;
    if ({p_hit, p_miss, p_inv, revealed, wrong_count} !== {3'b001, 8'h01, 3'd0}) begin
      miscompares++;
      $display("FAIL invalid_code got %b%b%b rev=%b wc=%0d exp 001 rev=00000001 wc=0", p_hit, p_miss, p_inv, revealed, wrong_count);
    end
  endtask

  task automatic test_repeat();
    start_game(STAY, 4'd4);
    do_guess(5'd3);
    vectors++;
    if ({p_miss, wrong_count} !== {1'b1, 3'd1}) begin
      miscompares++;
      $display("FAIL repeat_first got miss=%b wc=%0d exp miss=1 wc=1", p_miss, wrong_count);
    end
    do_guess(5'd3);
    vectors++;
`ifdef HANGMAN_GUESS_HISTORY_EN
    if ({p_miss, p_inv, wrong_count} !== {1'b0, 1'b1, 3'd1}) begin
      miscompares++;
      $display("FAIL repeat_second got miss=%b inv=%b wc=%0d exp 0 1 1", p_miss, p_inv, wrong_count);
    end
`else
    if ({p_miss, p_inv, wrong_count} !== {1'b1, 1'b0, 3'd2}) begin
      miscompares++;
      $display("FAIL repeat_second got miss=%b inv=%b wc=%0d exp 1 0 2", p_miss, p_inv, wrong_count);
    end
`endif
  endtask

  task automatic test_priority();
    start_game(STAY, 4'd4);
    do_guess(5'd18);
    guess = 5'd19; go = 1'b1;
    step();
    go = 1'b0; new_game = 1'b1;
    step();
    new_game = 1'b0;
    step(); step();
    vectors++;
    if ({hit, miss, invalid, revealed, wrong_count} !== 14'd0) begin
      miscompares++;
      $display("FAIL newgame_priority got %b%b%b rev=%b wc=%0d exp all 0", hit, miss, invalid, revealed, wrong_count);
    end
    do_guess(5'd19);
    vectors++;
    if ({p_hit, revealed} !== {1'b1, 8'h02}) begin
      miscompares++;
      $display("FAIL newgame_then_play got hit=%b rev=%b exp 1 00000010", p_hit, revealed);
    end
  endtask

  task automatic test_reset_eval();
    start_game(STAY, 4'd4);
    do_guess(5'd19);
    do_guess(5'd2);
    guess = 5'd18; go = 1'b1;
    step();
    go = 1'b0;
    step();
    resetn = 1'b0;
    #1;
    vectors++;
    if ({revealed, wrong_count, hit, miss, invalid, game_won, game_lost} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_async got %h exp 0000", {revealed, wrong_count, hit, miss, invalid, game_won, game_lost});
    end
    step();
    resetn = 1'b1;
    step();
    p_after = hit | miss | invalid;
    step();
    vectors++;
    if ({p_after, hit, miss, invalid, revealed, wrong_count} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_eval_no_pulse got %h exp 0000", {p_after, hit, miss, invalid, revealed, wrong_count});
    end
    do_guess(5'd18);
    vectors++;
    if ({p_hit, p_miss, p_inv, revealed} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_eval_idle got %b%b%b rev=%b exp 000 0", p_hit, p_miss, p_inv, revealed);
    end
  endtask

  task automatic test_len_bounds();
    start_game(40'd0, 4'd0);
    vectors++;
    if ({game_won, game_lost, revealed} !== {2'b10, 8'h00}) begin
      miscompares++;
      $display("FAIL len_zero got won=%b lost=%b rev=%b exp 1 0 0", game_won, game_lost, revealed);
    end
    start_game({8{5'd2}}, 4'd15);
    vectors++;
    if (game_won !== 1'b0) begin
      miscompares++;
      $display("FAIL len_clamp_play got won=%b exp 0", game_won);
    end
    do_guess(5'd2);
    vectors++;
    if ({p_hit, game_won, revealed} !== {2'b11, 8'hFF}) begin
      miscompares++;
      $display("FAIL len_clamp_full got hit=%b won=%b rev=%b exp 1 1 11111111", p_hit, game_won, revealed);
    end
    start_game({5'd2, 35'd0}, 4'd3);
    do_guess(5'd2);
    vectors++;
    if ({p_miss, revealed, wrong_count} !== {1'b1, 8'h00, 3'd1}) begin
      miscompares++;
      $display("FAIL len_short_mask got miss=%b rev=%b wc=%0d exp 1 0 1", p_miss, revealed, wrong_count);
    end
  endtask

  initial begin
    test_reset();
    test_reveal();
    test_win();
    test_loss();
    test_invalid();
    test_repeat();
    test_priority();
    test_reset_eval();
    test_len_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hangman_guess_engine.md
HANGMAN_GUESS_ENGINE -- requirements
Module: hangman_guess_engine

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum letters per word, legal range 1..16.
REQ-002 Parameter MAX_WRONG, default 6: number of wrong guesses that ends the game as lost, legal range 1..15.
REQ-003 Clock, reset and ports (LW = $clog2(MAX_LEN+1), WW = $clog2(MAX_WRONG+1)):
- clk  in  1  single clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- new_game  in  1  level, sampled each clk; loads word and word_len and starts a game.
- word  in  5*MAX_LEN  letter i is word[5i+4:5i]; A=0 .. Z=25.
- word_len  in  LW  number of active letters.
- guess  in  5  letter code under test.
- go  in  1  level; a guess is committed when go is released.
- revealed  out  MAX_LEN  bit i = 1 when letter i has been guessed.
- wrong_count  out  WW  wrong guesses so far.
- hit  out  1  one-cycle pulse: last guess matched at least one letter.
- miss  out  1  one-cycle pulse: last guess was wrong.
- invalid  out  1  one-cycle pulse: last guess was ignored.
- game_won  out  1  level.
- game_lost  out  1  level.

Function
REQ-004 States: IDLE, PLAY, ARMED, EVAL, WON, LOST.
REQ-005 IDLE: all guesses are ignored. Exit is only through new_game.
REQ-006 new_game=1 in any state has priority over all other inputs.
- Latches word and clamped word_len; values above MAX_LEN become MAX_LEN.
- Clears revealed, wrong_count, hit, miss, invalid and history.
- Next state is PLAY, or WON when word_len=0.
REQ-007 PLAY moves to ARMED when go=1. ARMED holds while go=1 and moves to EVAL when go=0. Holding go high therefore commits exactly one guess.
REQ-008 guess is sampled in the ARMED->EVAL cycle and held internally. Changes to guess during EVAL have no effect.
REQ-009 EVAL lasts exactly one cycle. It compares the guess against all positions i < word_len in parallel, and ignores positions >= word_len.
REQ-010 At the end of EVAL, when guess is valid (<=25):
- Every matching position sets its revealed bit, in the same edge. Duplicate letters are all revealed together.
- hit=1 if any position matched. Otherwise miss=1 and wrong_count increments by 1.
REQ-011 A guess of 26..31 gives invalid=1. revealed and wrong_count are unchanged.
REQ-012 Result timing:
- hit, miss and invalid are registered. Each is high only in the cycle after EVAL, and at most one of them is high.
- Latency from go falling, as sampled, to the pulse is 2 clk cycles.
REQ-013 Next state after EVAL:
- WON if all revealed[word_len-1:0]=1.
- Else LOST if wrong_count reaches MAX_WRONG.
- Else PLAY.
REQ-014 wrong_count never exceeds MAX_WRONG and never wraps.
REQ-015 Output levels:
- game_won=1 exactly in WON; game_lost=1 exactly in LOST.
- WON and LOST ignore go and guess and hold revealed and wrong_count until new_game.
REQ-016 revealed bits at index >= word_len always read 0.

Reset
REQ-017 While resetn=0, regardless of clk:
- state=IDLE.
- revealed=0, wrong_count=0.
- hit=miss=invalid=0, game_won=game_lost=0.
- Latched word, latched word_len and history are cleared.
REQ-018 Reset asserted during ARMED or EVAL discards the pending guess; no pulse is produced after release.
REQ-019 Reset deassertion takes effect on the first clk edge; the block waits in IDLE for new_game.

Configuration
REQ-020 Macro HANGMAN_GUESS_HISTORY_EN:
- Defined: a 26-bit history register is set by each valid evaluated guess and cleared by reset and by new_game. A valid guess already in history gives invalid=1, with no change to revealed or wrong_count.
- Undefined: there is no history register. A repeated wrong guess increments wrong_count again; a repeated correct guess gives hit=1 again.

Verification
REQ-021 Reveal: new_game with word "BOOK" (1,14,14,10), word_len=4, then guess 14 with a go pulse -> revealed=0110, hit=1 for one cycle, wrong_count=0.
REQ-022 Win: word "STAY" (18,19,0,24), guesses 18,19,0,24 -> after the 4th guess game_won=1, revealed=1111, state WON; a further guess 3 gives no pulse.
REQ-023 Loss: word "STAY", MAX_WRONG=6, six distinct wrong guesses -> miss on each, wrong_count goes 1..6, game_lost=1 after the sixth, and a 7th guess leaves wrong_count=6.
REQ-024 Invalid guess: guess 30 -> invalid=1; revealed and wrong_count unchanged.
REQ-025 Repeat guess: guess 3 twice -> with the macro, miss then invalid and wrong_count=1; without it, two misses and wrong_count=2.
REQ-026 Priority and reset:
- new_game asserted while ARMED, in the same cycle go falls -> guess dropped, state PLAY, revealed=0.
- resetn pulsed low during EVAL -> all outputs 0, state IDLE, no pulse.
